net_ingress_shaper: RTL

//  Ingress stage feeding one switch input port (network_if.IN side of the 2x2 switch).
//  - Accepts 32-bit payload words plus a destination bit from a traffic source.
//  - Stamps the 34-bit switch word {SRC_ID, dst, payload} and buffers it in a DEPTH-entry FIFO.
//  - Releases words under a token-bucket rate limit; an enable/drain FSM allows clean stop.

---
 rtl/net_ingress_shaper.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/net_ingress_shaper.sv
// Ingress shaper for one switch port: stamps {SRC_ID, dst, payload}, buffers in a FIFO,
// releases under a token-bucket limit. Optional counters via NET_INGRESS_STATS_EN.
//
// state | meaning
// IDLE  | not accepting, not emitting; bucket keeps refilling
// RUN   | accepting and emitting words
// DRAIN | not accepting, emitting until the FIFO is empty
module net_ingress_shaper #(
    parameter logic SRC_ID      = 1'b0,
    parameter int   DEPTH       = 4,
    parameter int   BURST       = 4,
    parameter int   RATE_PERIOD = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_in_vld,
    output logic        o_in_rdy,
    input  logic        i_in_dst,
    input  logic [31:0] i_in_data,
    output logic        o_out_vld,
    input  logic        i_out_rdy,
    output logic [33:0] o_out_data,
    output logic        o_busy
`ifdef NET_INGRESS_STATS_EN
    ,
    output logic [15:0] o_stat_dst0,
    output logic [15:0] o_stat_dst1,
    output logic [15:0] o_stat_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BURST + 1);
    localparam int CW = (RATE_PERIOD > 1) ? $clog2(RATE_PERIOD) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TOK_MAX  = TW'(BURST);
    localparam logic [CW-1:0] CTR_LAST = CW'(RATE_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        r_state;
    logic [33:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic [TW-1:0] r_tokens;
    logic [CW-1:0] r_refill;

    logic          w_push;
    logic          w_pop;
    logic          w_refill;
    logic [AW:0]   w_count_nxt;

    // All handshake outputs decode registered state only, so out_vld cannot
    // fall until the word it presents has been taken.
    assign o_in_rdy   = (r_state == S_RUN) && (r_count < FULL_CNT);
    assign o_out_vld  = (r_count != '0) && (r_tokens != '0) && (r_state != S_IDLE);
    assign o_out_data = o_out_vld ? r_mem[r_rd] : '0;
    assign o_busy     = (r_state != S_IDLE) || (r_count != '0);

    assign w_push   = i_in_vld && o_in_rdy;
    assign w_pop    = o_out_vld && i_out_rdy;
    assign w_refill = (r_refill == CTR_LAST);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + (AW + 1)'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - (AW + 1)'(1);
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr] <= {SRC_ID, i_in_dst, i_in_data};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_tokens <= TOK_MAX;
            r_refill <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_count  <= w_count_nxt;
            r_refill <= w_refill ? '0 : r_refill + CW'(1);

            // A refill that lands on a consume cancels out.
            if (w_refill && !w_pop && (r_tokens != TOK_MAX))
                r_tokens <= r_tokens + TW'(1);
            else if (!w_refill && w_pop)
                r_tokens <= r_tokens - TW'(1);

            case (r_state)
                S_IDLE: begin
                    if (i_en)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (!i_en)
                        r_state <= (w_count_nxt != '0) ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (w_count_nxt == '0)
                        r_state <= S_IDLE;
                    else if (i_en)
                        r_state <= S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef NET_INGRESS_STATS_EN
    logic [15:0] r_stat_dst0;
    logic [15:0] r_stat_dst1;
    logic [15:0] r_stat_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stat_dst0  <= '0;
            r_stat_dst1  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_pop && !o_out_data[32] && (r_stat_dst0 != 16'hFFFF))
                r_stat_dst0 <= r_stat_dst0 + 16'd1;
            if (w_pop && o_out_data[32] && (r_stat_dst1 != 16'hFFFF))
                r_stat_dst1 <= r_stat_dst1 + 16'd1;
            if ((r_count != '0) && (r_tokens == '0) && (r_stat_stall != 16'hFFFF))
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign o_stat_dst0  = r_stat_dst0;
    assign o_stat_dst1  = r_stat_dst1;
    assign o_stat_stall = r_stat_stall;
`endif

endmodule
